// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu - load/store unit driving a synchronous word-wide data memory.
//
// Accepts one RISC-V load/store at a time over a valid/ready handshake,
// produces the word address and byte-lane write mask, lane-aligns store
// data, and aligns plus sign/zero-extends load data. Exactly one completion
// response (rsp_valid pulse) is returned per accepted request.
//
// Optional feature macro: DMEM_LSU_MISALIGN_EN
//   defined   : misaligned legal accesses run as two memory beats
//   undefined : misaligned accesses fault; the two-beat path is not built
//
// Ports:
//   clk, resetn                clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store flag and RISC-V access width/sign code
//   req_addr, req_wdata        byte address, right-justified store data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_fault       extended load data / fault flag (valid with pulse)
//   mem_addr, mem_wmask        registered word address and byte write enables
//   mem_wdata                  registered lane-aligned store data
//   mem_rdata                  read word, valid the cycle after address sample
// ---------------------------------------------------------------------------
module dmem_lsu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
`ifdef DMEM_LSU_MISALIGN_EN
        ST_BEAT1 = 3'd2,
`endif
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      state_r;
    logic        ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_fault_r;
    logic [29:0] addr_r;
    logic [3:0]  wmask_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic [1:0]  size_r;     // funct3[1:0]: 00 byte, 01 half, 10 word
    logic        uns_r;      // funct3[2]: zero-extend
    logic [1:0]  off_r;
`ifdef DMEM_LSU_MISALIGN_EN
    logic        split_r;
    logic [31:0] rd0_r;      // beat-0 read word of a split load
    logic [3:0]  wmask_hi_r;
    logic [31:0] wdata_hi_r;
    logic [3:0]  mask_hi_s;
    logic [31:0] wdata_hi_s;
    logic        split_s;
`endif

    logic [1:0]  off_s;
    logic        illegal_s;
    logic        misalign_s;
    logic        fault_s;
    logic [3:0]  smask_s;
    logic [3:0]  mask_lo_s;
    logic [31:0] wdata_lo_s;
    logic [31:0] lo_s;
    logic [23:0] hi_s;       // only 3 bytes of the second word can ever be needed
    logic [31:0] shifted_s;
    logic [31:0] ext_s;

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_fault = rsp_fault_r;
    assign mem_addr  = addr_r;
    assign mem_wmask = wmask_r;
    assign mem_wdata = wdata_r;

    // Request decode: legality, alignment and the 64-bit lane shift of mask/data.
    always_comb begin
        off_s = req_addr[1:0];
        if (req_we) begin
            illegal_s = (req_funct3 > 3'd2);
        end else begin
            illegal_s = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misalign_s = ((req_funct3[1:0] == 2'b01) && (off_s == 2'b11)) ||
                     ((req_funct3[1:0] == 2'b10) && (off_s != 2'b00));
`ifdef DMEM_LSU_MISALIGN_EN
        fault_s = illegal_s;
        split_s = ~illegal_s & misalign_s;
`else
        fault_s = illegal_s | misalign_s;
`endif
        case (req_funct3[1:0])
            2'b00:   smask_s = 4'b0001;
            2'b01:   smask_s = 4'b0011;
            2'b10:   smask_s = 4'b1111;
            default: smask_s = 4'b0000;
        endcase
        // Low word of ({mask} << o) and ({32'b0, wdata} << 8*o).
        case (off_s)
            2'd0: begin
                mask_lo_s  = smask_s;
                wdata_lo_s = req_wdata;
            end
            2'd1: begin
                mask_lo_s  = {smask_s[2:0], 1'b0};
                wdata_lo_s = {req_wdata[23:0], 8'h00};
            end
            2'd2: begin
                mask_lo_s  = {smask_s[1:0], 2'b00};
                wdata_lo_s = {req_wdata[15:0], 16'h0000};
            end
            2'd3: begin
                mask_lo_s  = {smask_s[0], 3'b000};
                wdata_lo_s = {req_wdata[7:0], 24'h000000};
            end
            default: begin
                mask_lo_s  = 4'b0000;
                wdata_lo_s = 32'h0000_0000;
            end
        endcase
`ifdef DMEM_LSU_MISALIGN_EN
        // High word of the same shifts, used for the second beat.
        case (off_s)
            2'd0: begin
                mask_hi_s  = 4'b0000;
                wdata_hi_s = 32'h0000_0000;
            end
            2'd1: begin
                mask_hi_s  = {3'b000, smask_s[3]};
                wdata_hi_s = {24'h000000, req_wdata[31:24]};
            end
            2'd2: begin
                mask_hi_s  = {2'b00, smask_s[3:2]};
                wdata_hi_s = {16'h0000, req_wdata[31:16]};
            end
            2'd3: begin
                mask_hi_s  = {1'b0, smask_s[3:1]};
                wdata_hi_s = {8'h00, req_wdata[31:8]};
            end
            default: begin
                mask_hi_s  = 4'b0000;
                wdata_hi_s = 32'h0000_0000;
            end
        endcase
`endif
    end

    // Load alignment: ({beat1, beat0} >> 8*o), then sign/zero extension.
    always_comb begin
`ifdef DMEM_LSU_MISALIGN_EN
        lo_s = split_r ? rd0_r : mem_rdata;
        hi_s = split_r ? mem_rdata[23:0] : 24'h000000;
`else
        lo_s = mem_rdata;
        hi_s = 24'h000000;
`endif
        case (off_r)
            2'd0:    shifted_s = lo_s;
            2'd1:    shifted_s = {hi_s[7:0],  lo_s[31:8]};
            2'd2:    shifted_s = {hi_s[15:0], lo_s[31:16]};
            2'd3:    shifted_s = {hi_s[23:0], lo_s[31:24]};
            default: shifted_s = 32'h0000_0000;
        endcase
        case (size_r)
            2'b00:   ext_s = {{24{~uns_r & shifted_s[7]}},  shifted_s[7:0]};
            2'b01:   ext_s = {{16{~uns_r & shifted_s[15]}}, shifted_s[15:0]};
            default: ext_s = shifted_s;
        endcase
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_fault_r <= 1'b0;
            addr_r      <= 30'd0;
            wmask_r     <= 4'b0000;
            wdata_r     <= 32'h0000_0000;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            off_r       <= 2'b00;
`ifdef DMEM_LSU_MISALIGN_EN
            split_r     <= 1'b0;
            rd0_r       <= 32'h0000_0000;
            wmask_hi_r  <= 4'b0000;
            wdata_hi_r  <= 32'h0000_0000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        ready_r <= 1'b0;
                        if (fault_s) begin
                            // No memory access: straight to the response.
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_fault_r <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_BEAT0;
                            we_r    <= req_we;
                            size_r  <= req_funct3[1:0];
                            uns_r   <= req_funct3[2];
                            off_r   <= off_s;
                            addr_r  <= req_addr[31:2];
                            wmask_r <= req_we ? mask_lo_s : 4'b0000;
                            wdata_r <= wdata_lo_s;
`ifdef DMEM_LSU_MISALIGN_EN
                            split_r    <= split_s;
                            wmask_hi_r <= req_we ? mask_hi_s : 4'b0000;
                            wdata_hi_r <= wdata_hi_s;
`endif
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_BEAT0: begin
`ifdef DMEM_LSU_MISALIGN_EN
                    if (split_r) begin
                        state_r <= ST_BEAT1;
                        addr_r  <= addr_r + 30'd1;   // wraps modulo 2^30
                        wmask_r <= wmask_hi_r;
                        wdata_r <= wdata_hi_r;
                    end else begin
                        state_r <= ST_DATA;
                        wmask_r <= 4'b0000;
                    end
`else
                    state_r <= ST_DATA;
                    wmask_r <= 4'b0000;
`endif
                end
`ifdef DMEM_LSU_MISALIGN_EN
                ST_BEAT1: begin
                    // mem_rdata now holds the beat-0 word.
                    rd0_r   <= mem_rdata;
                    wmask_r <= 4'b0000;
                    state_r <= ST_DATA;
                end
`endif
                ST_DATA: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= we_r ? 32'h0000_0000 : ext_s;
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    wmask_r     <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu - scoreboard bench for dmem_lsu with a 16-word memory model.
// Expected responses and expected write beats are queued when a request is
// driven and compared when the DUT produces them. Response timing is
// measured as the number of clock edges between the accept edge and the
// edge that raised rsp_valid (aligned 2, split 3, fault 0).
// Build with DMEM_LSU_MISALIGN_EN defined to exercise the two-beat path.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wq[$];
    rsp_t rsp_pend;
    wr_t  wr_exp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:15] = '{32'h44332211, 32'h88776655, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0};

    dmem_lsu dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: address/mask/data sampled at the edge, read next cycle.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[3:0]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: compare responses and write beats against the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_val("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_pend = rsp_q.pop_front();
                    check_val("rsp_rdata", rsp_rdata, rsp_pend.rd);
                    check_val("rsp_fault", {31'd0, rsp_fault}, {31'd0, rsp_pend.flt});
                    check_val("rsp_edges", cyc - rsp_pend.acc, rsp_pend.lat);
                end
            end
            if (mem_wmask != 4'b0000) begin
                if (wq.size() == 0) begin
                    check_val("wr_unexpected", {28'd0, mem_wmask}, 32'd0);
                end else begin
                    wr_exp = wq.pop_front();
                    check_val("wr_addr", {2'b00, mem_addr}, {2'b00, wr_exp.a});
                    check_val("wr_mask", {28'd0, mem_wmask}, {28'd0, wr_exp.m});
                    check_val("wr_data", mem_wdata, wr_exp.d);
                end
            end
        end
    end

    task automatic push_wr(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_t w;
        w.a = a; w.m = m; w.d = d;
        wq.push_back(w);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_flt, input int exp_lat);
        int   n;
        rsp_t r;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_val("ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        r.rd = exp_rd; r.flt = exp_flt; r.lat = exp_lat; r.acc = cyc;
        rsp_q.push_back(r);
        req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            check_val("rsp_timeout", 32'd0, 32'd1);
            rsp_q.delete();
        end
    endtask

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        check_val("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Loads on the preloaded image.
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h44332211, 1'b0, 2);
        do_req(1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        do_req(1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 2);
        do_req(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8877, 1'b0, 2);
        do_req(1'b0, 3'b101, 32'h2, 32'h0, 32'h00004433, 1'b0, 2);
        do_req(1'b0, 3'b001, 32'h5, 32'h0, 32'h00007766, 1'b0, 2);
`ifdef DMEM_LSU_MISALIGN_EN
        do_req(1'b0, 3'b010, 32'h3, 32'h0, 32'h77665544, 1'b0, 3);
        do_req(1'b0, 3'b101, 32'h3, 32'h0, 32'h00005544, 1'b0, 3);
`else
        do_req(1'b0, 3'b010, 32'h3, 32'h0, 32'h0, 1'b1, 0);
        do_req(1'b0, 3'b101, 32'h3, 32'h0, 32'h0, 1'b1, 0);
`endif
        // Illegal funct3 for a load and for a store.
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        do_req(1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);

        // SH 0x2 then read back.
        push_wr(30'd0, 4'b1100, 32'hABCD0000);
        do_req(1'b1, 3'b001, 32'h2, 32'h0000ABCD, 32'h0, 1'b0, 2);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hABCD2211, 1'b0, 2);

`ifdef DMEM_LSU_MISALIGN_EN
        // Split SW across words 1/2.
        push_wr(30'd1, 4'b1100, 32'hBEEF0000);
        push_wr(30'd2, 4'b0011, 32'h0000DEAD);
        do_req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'hBEEF6655, 1'b0, 2);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 32'h0000DEAD, 1'b0, 2);

        // Reset during beat 1 of a split SW: beat 0 lands, beat 1 never does.
        push_wr(30'd1, 4'b1100, 32'h56780000);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h6;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check_val("beat1_mask", {28'd0, mem_wmask}, 32'h3);
        resetn = 1'b0;
        #1;
        check_val("rst_mid_wmask", {28'd0, mem_wmask}, 32'd0);
        check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mid_word1", mem[1], 32'h56786655);
        check_val("rst_mid_word2", mem[2], 32'h0000DEAD);
        @(negedge clk);
        resetn = 1'b1;
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h56786655, 1'b0, 2);

        // Split store and load wrapping from word 0x3FFFFFFF to word 0.
        push_wr(30'h3FFFFFFF, 4'b1100, 32'hABCD0000);
        push_wr(30'h0, 4'b0011, 32'h00001234);
        do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'h1234ABCD, 32'h0, 1'b0, 3);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hABCD1234, 1'b0, 2);
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h1234ABCD, 1'b0, 3);
`else
        // Misaligned store faults and leaves memory alone.
        do_req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, 32'h0, 1'b1, 0);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h88776655, 1'b0, 2);
        do_req(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b1, 0);
        check_val("word2_untouched", mem[2], 32'h0);

        // Reset while an aligned store beat is on the bus: the write is dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("beat0_mask", {28'd0, mem_wmask}, 32'hF);
        resetn = 1'b0;
        #1;
        check_val("rst_mid_wmask", {28'd0, mem_wmask}, 32'd0);
        check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mid_word2", mem[2], 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hABCD2211, 1'b0, 2);
`endif

        repeat (3) @(negedge clk);
        check_val("wr_pending", wq.size(), 32'd0);
        check_val("rsp_pending", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that is the requesting side of the synchronous word-wide data memory port: `mem_addr`/`mem_wmask`/`mem_wdata` are sampled at a clock edge, and `mem_rdata` is valid in the following cycle. It accepts one RISC-V load or store at a time from the memory stage over a valid/ready handshake. It generates word addresses and byte-lane masks, aligns store data, and aligns and sign- or zero-extends load data. It returns a single completion response per request.

## Interface
Parameters: none. Address width is fixed at 32 bits; the memory word address is 30 bits.

- `clk`  in  1  clock; all state updates on the rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults
- `rsp_fault`  out  1  misaligned or illegal request
- `mem_addr`  out  30  word address (registered)
- `mem_wmask`  out  4  byte write enables (registered); 0 whenever no write beat is active
- `mem_wdata`  out  32  lane-aligned store data (registered)
- `mem_rdata`  in  32  memory read word, valid the cycle after the address is sampled

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - BEAT0: first memory access.
  - BEAT1: second memory access, split accesses only.
  - DATA: last read word arrives.
  - RESP: `rsp_valid` = 1.
- Request decode, with size 1/2/4 and offset o = `req_addr[1:0]`:
  - Illegal `req_funct3` (loads 011/110/111; stores any value above 010) -> fault.
  - Misaligned means LH/LHU/SH with o = 3, or LW/SW with o != 0. Misaligned -> split, or fault (see Configuration).
  - Any fault -> IDLE->RESP with no memory access.
- Accept: `req_valid` & `req_ready` at an edge latches the request and loads the beat-0 `mem_*` registers -> BEAT0.
- Beat 0:
  - `mem_addr` = `req_addr[31:2]`.
  - `mem_wmask` = size-mask << o, truncated to 4 bits; forced to 0 for loads.
  - `mem_wdata` = low 32 bits of ({32'b0, `req_wdata`} << 8·o).
- Beat 1:
  - `mem_addr` = beat-0 address + 1. This wraps modulo 2^30, so 0x3FFFFFFF -> 0.
  - `mem_wmask` = bits [7:4] of the 8-bit (size-mask << o).
  - `mem_wdata` = high 32 bits of the same 64-bit shift.
- BEAT0 -> BEAT1 if split, else -> DATA. `mem_wmask` is cleared on leaving BEAT0/BEAT1, so each write occurs exactly once.
- Read capture:
  - In DATA, or in BEAT1 for beat 0, `mem_rdata` is captured.
  - The load result is ({beat1, beat0} >> 8·o). Take the low size bytes, sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Non-split loads use beat1 = 0.
- DATA -> RESP. RESP -> IDLE after one cycle. `rsp_rdata`/`rsp_fault` are valid only while `rsp_valid` = 1 and are 0 otherwise.
- Inputs are ignored outside IDLE. There is no back-pressure on the response.

## Timing
- Let E0 be the accept edge.
- Aligned request: `mem_*` beat 0 is valid after E0 and sampled by memory at E1. `rsp_valid` is high in the cycle after E2, i.e. 3 cycles from accept. `req_ready` is high again after E3.
- Split request: beat 0 is sampled at E1 and beat 1 at E2. `rsp_valid` is high in the cycle after E3.
- Fault: `rsp_valid` is high in the cycle after E0.
- Reset (`resetn` low, asynchronous):
  - state = IDLE, `req_ready` = 1.
  - `rsp_valid`, `rsp_fault`, `rsp_rdata`, `mem_addr`, `mem_wmask`, `mem_wdata` = 0.
  - A split store interrupted after beat 0 leaves the beat-0 bytes written. This is accepted behaviour.

## Configuration
- `DMEM_LSU_MISALIGN_EN` defined: misaligned legal requests are executed as two beats as described above.
- Not defined: misaligned requests fault (`rsp_fault` = 1, `rsp_rdata` = 0, no `mem_wmask` activity, 1-cycle response), and state BEAT1 is not built.
- Illegal funct3 faults in both builds.

## Test plan
All scenarios preload word 0 = 0x44332211 and word 1 = 0x88776655.

- LW 0x0 -> `rsp_rdata` = 0x44332211 and `rsp_fault` = 0, `rsp_valid` 3 cycles after accept, `mem_wmask` = 0 throughout.
- LB 0x7 -> 0xFFFFFF88; LBU 0x7 -> 0x00000088; LH 0x6 -> 0xFFFF8877; LHU 0x2 -> 0x00004433.
- SH 0x2 with data 0x0000ABCD -> one beat with `mem_wmask` 1100 and `mem_wdata` 0xABCD0000. A following LW 0x0 returns 0xABCD2211.
- With the macro:
  - LW 0x3 -> beats at word 0 then word 1, result 0x77665544 four cycles after accept.
  - SW 0x6 with data 0xDEADBEEF -> beat 0 at word 1 with mask 1100 and data 0xBEEF0000; beat 1 at word 2 with mask 0011 and data 0x0000DEAD.
- Without the macro: LW 0x3 -> `rsp_fault` = 1, `rsp_rdata` = 0, response the cycle after accept, memory untouched.
- Load with funct3 011 -> fault in both builds.
- Assert `resetn` during BEAT1 of a split SW -> `mem_wmask` drops to 0 immediately with no beat-1 write, `rsp_valid` never pulses, `req_ready` = 1.
